// File: rtl/cv32e40p_x_offload_ctrl.sv
// Offload controller between the ID stage and an X-interface coprocessor.
// It tracks in-flight writeback offloads and routes their results to the register file.
module cv32e40p_x_offload_ctrl #(
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 id_req_i,
   input  logic [2:0][31:0]     id_rs_i,
   input  logic [2:0][4:0]      id_rs_addr_i,
   input  logic [2:0]           id_rs_used_i,
   input  logic [4:0]           id_rd_addr_i,
   output logic                 id_ready_o,
   output logic                 id_illegal_o,
   output logic                 x_valid_o,
   input  logic                 x_ready_i,
   output logic [2:0][31:0]     x_rs_o,
   output logic [2:0]           x_rs_valid_o,
   output logic                 x_rd_clean_o,
   input  logic                 x_accept_i,
   input  logic                 x_writeback_i,
   input  logic                 x_rvalid_i,
   output logic                 x_rready_o,
   input  logic [4:0]           x_rd_i,
   input  logic [31:0]          x_data_i,
   input  logic                 x_error_i,
   input  logic                 wb_gnt_i,
   output logic                 wb_we_o,
   output logic [4:0]           wb_waddr_o,
   output logic [31:0]          wb_wdata_o,
   output logic                 x_err_o,
   output logic                 spurious_o,
   output logic                 busy_o
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {IDLE, STALL, REQ} state_e;

   state_e          r_state;
   state_e          w_state_next;
   logic [31:0]     r_pending;
   logic [31:0]     w_pending_next;
   logic [CW-1:0]   r_count;
   logic            r_wb_we;
   logic [4:0]      r_wb_waddr;
   logic [31:0]     r_wb_wdata;
   logic            r_x_err;
   logic            r_spurious;

   logic            w_hazard;
   logic            w_handshake;
   logic            w_issue;
   logic            w_resp;
   logic            w_dec;
   logic            w_resp_pending;
   logic            w_write;
   logic            w_spurious;

   // An operand or destination still owed by the coprocessor, or a full scoreboard, blocks issue.
   always_comb begin
      w_hazard = r_pending[id_rd_addr_i] || (r_count == CW'(MAX_OUTSTANDING));
      for (int i = 0; i < 3; i++) begin
         if (id_rs_used_i[i] && r_pending[id_rs_addr_i[i]]) begin
            w_hazard = 1'b1;
         end
      end
   end

   assign w_handshake    = (r_state == REQ) && x_ready_i;
   assign w_issue        = w_handshake && x_accept_i && x_writeback_i;
   assign w_resp         = x_rvalid_i && wb_gnt_i;
   assign w_dec          = w_resp && (r_count != '0);
   assign w_resp_pending = r_pending[x_rd_i];
   assign w_write        = w_resp && !x_error_i && (x_rd_i != 5'd0) && w_resp_pending;
   assign w_spurious     = w_resp && (x_rd_i != 5'd0) && !w_resp_pending;

   // A new issue to the same rd as a retiring response wins, since that rd is owed again.
   always_comb begin
      w_pending_next = r_pending;
      if (w_resp) begin
         w_pending_next[x_rd_i] = 1'b0;
      end
      if (w_issue) begin
         w_pending_next[id_rd_addr_i] = 1'b1;
      end
      w_pending_next[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (id_req_i) w_state_next = w_hazard ? STALL : REQ;
         STALL:   if (!id_req_i) w_state_next = IDLE;
                  else if (!w_hazard) w_state_next = REQ;
         REQ:     if (x_ready_i) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      x_valid_o    = (r_state == REQ);
      x_rd_clean_o = (r_state == REQ);
      x_rs_o       = id_rs_i;
      x_rs_valid_o = (r_state == REQ) ? id_rs_used_i : 3'b000;
      id_ready_o   = w_handshake;
      id_illegal_o = w_handshake && !x_accept_i;
      x_rready_o   = wb_gnt_i;
      busy_o       = (r_count != '0) || (r_state != IDLE);
   end

   // Scoreboard and registered result path; a decrement at zero is dropped so the count cannot wrap.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_pending  <= '0;
         r_count    <= '0;
         r_wb_we    <= 1'b0;
         r_wb_waddr <= '0;
         r_wb_wdata <= '0;
         r_x_err    <= 1'b0;
         r_spurious <= 1'b0;
      end else begin
         r_pending  <= w_pending_next;
         if (w_issue && !w_dec) begin
            r_count <= r_count + 1'b1;
         end else if (!w_issue && w_dec) begin
            r_count <= r_count - 1'b1;
         end
         r_wb_we    <= w_write;
         if (w_write) begin
            r_wb_waddr <= x_rd_i;
            r_wb_wdata <= x_data_i;
         end
         r_x_err    <= w_resp && x_error_i;
         r_spurious <= w_spurious;
      end
   end

   assign wb_we_o    = r_wb_we;
   assign wb_waddr_o = r_wb_waddr;
   assign wb_wdata_o = r_wb_wdata;
   assign x_err_o    = r_x_err;
   assign spurious_o = r_spurious;

endmodule

// File: tb/tb_cv32e40p_x_offload_ctrl.sv
// Directed bench for the X offload controller: a cycle table for the basic flows,
// then hand-written sequences for stalls, back-pressure, errors and reset.
module tb_cv32e40p_x_offload_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rstN;
   logic              idReq;
   logic [2:0][31:0]  idRs;
   logic [2:0][4:0]   idRsAddr;
   logic [2:0]        idRsUsed;
   logic [4:0]        idRdAddr;
   logic              idReady, idIllegal;
   logic              xValid, xReady;
   logic [2:0][31:0]  xRs;
   logic [2:0]        xRsValid;
   logic              xRdClean, xAccept, xWriteback;
   logic              xRvalid, xRready;
   logic [4:0]        xRd;
   logic [31:0]       xData;
   logic              xError, wbGnt, wbWe;
   logic [4:0]        wbWaddr;
   logic [31:0]       wbWdata;
   logic              xErr, spurious, busy;

   int checks = 0;
   int errors = 0;

   cv32e40p_x_offload_ctrl #(.MAX_OUTSTANDING(4)) dut (
      .clk_i(clk), .rst_ni(rstN), .id_req_i(idReq), .id_rs_i(idRs),
      .id_rs_addr_i(idRsAddr), .id_rs_used_i(idRsUsed), .id_rd_addr_i(idRdAddr),
      .id_ready_o(idReady), .id_illegal_o(idIllegal), .x_valid_o(xValid),
      .x_ready_i(xReady), .x_rs_o(xRs), .x_rs_valid_o(xRsValid),
      .x_rd_clean_o(xRdClean), .x_accept_i(xAccept), .x_writeback_i(xWriteback),
      .x_rvalid_i(xRvalid), .x_rready_o(xRready), .x_rd_i(xRd), .x_data_i(xData),
      .x_error_i(xError), .wb_gnt_i(wbGnt), .wb_we_o(wbWe), .wb_waddr_o(wbWaddr),
      .wb_wdata_o(wbWdata), .x_err_o(xErr), .spurious_o(spurious), .busy_o(busy)
   );

   typedef struct {
      logic        rstN, idReq;
      logic [4:0]  rd;
      logic        xReady, accept, wb, rvalid, gnt;
      logic [4:0]  xRd;
      logic [31:0] xData;
      logic        expValid, expReady, expIllegal, expBusy, expWe;
      logic [4:0]  expWaddr;
      logic [31:0] expWdata;
   } vec_t;

   vec_t vecs[17];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic clearInputs();
      rstN = 1'b1; idReq = 1'b0; idRs = '0; idRsAddr = '0; idRsUsed = '0;
      idRdAddr = '0; xReady = 1'b0; xAccept = 1'b0; xWriteback = 1'b0;
      xRvalid = 1'b0; xRd = '0; xData = '0; xError = 1'b0; wbGnt = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic applyStimulus(input vec_t v);
      rstN = v.rstN; idReq = v.idReq; idRdAddr = v.rd; xReady = v.xReady;
      xAccept = v.accept; xWriteback = v.wb; xRvalid = v.rvalid; wbGnt = v.gnt;
      xRd = v.xRd; xData = v.xData; idRsUsed = '0; xError = 1'b0;
   endtask

   // Issues one accepted writeback offload from IDLE; returns one edge after the handshake.
   task automatic issue(input logic [4:0] rd);
      idReq = 1'b1; idRdAddr = rd; idRsUsed = '0;
      xReady = 1'b1; xAccept = 1'b1; xWriteback = 1'b1;
      settle();
      checkOutput("issue_idle_valid", xValid, 0);
      cyc();
      settle();
      checkOutput("issue_handshake", idReady, 1);
      cyc();
      idReq = 1'b0; xReady = 1'b0; xAccept = 1'b0; xWriteback = 1'b0;
   endtask

   // Presents one response with the write port granted for a single cycle.
   task automatic respond(input logic [4:0] rd, input logic [31:0] data, input logic err);
      xRvalid = 1'b1; wbGnt = 1'b1; xRd = rd; xData = data; xError = err;
      settle();
      checkOutput("resp_rready", xRready, 1);
      cyc();
      xRvalid = 1'b0; wbGnt = 1'b0; xError = 1'b0;
   endtask

   initial begin
      // rstN idReq rd rdy acc wb rv gnt xRd xData | valid ready illegal busy we waddr wdata
      vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0};
      vecs[1]  = '{1, 1, 5, 1, 1, 1, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0};
      vecs[2]  = '{1, 1, 5, 1, 1, 1, 0, 0, 0, 0,            1, 1, 0, 1, 0, 0, 0};
      vecs[3]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1, 0, 0, 0};
      vecs[4]  = '{1, 0, 0, 0, 0, 0, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 0};
      vecs[5]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 1, 5, 32'hDEADBEEF};
      vecs[6]  = '{1, 1, 6, 1, 1, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0};
      vecs[7]  = '{1, 1, 6, 1, 1, 0, 0, 0, 0, 0,            1, 1, 0, 1, 0, 0, 0};
      vecs[8]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0};
      vecs[9]  = '{1, 1, 0, 1, 1, 1, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0};
      vecs[10] = '{1, 1, 0, 1, 1, 1, 0, 0, 0, 0,            1, 1, 0, 1, 0, 0, 0};
      vecs[11] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1, 0, 0, 0};
      vecs[12] = '{1, 0, 0, 0, 0, 0, 1, 1, 0, 32'h1234,     0, 0, 0, 1, 0, 0, 0};
      vecs[13] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0};
      vecs[14] = '{1, 1, 7, 1, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0};
      vecs[15] = '{1, 1, 7, 1, 0, 0, 0, 0, 0, 0,            1, 1, 1, 1, 0, 0, 0};
      vecs[16] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0};

      clearInputs();
      rstN = 1'b0;
      cyc();
      cyc();

      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i]);
         settle();
         checkOutput($sformatf("vec%0d_x_valid", i), xValid, vecs[i].expValid);
         checkOutput($sformatf("vec%0d_id_ready", i), idReady, vecs[i].expReady);
         checkOutput($sformatf("vec%0d_id_illegal", i), idIllegal, vecs[i].expIllegal);
         checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].expBusy);
         checkOutput($sformatf("vec%0d_wb_we", i), wbWe, vecs[i].expWe);
         checkOutput($sformatf("vec%0d_spurious", i), spurious, 0);
         if (vecs[i].expWe) begin
            checkOutput($sformatf("vec%0d_waddr", i), wbWaddr, vecs[i].expWaddr);
            checkOutput($sformatf("vec%0d_wdata", i), wbWdata, vecs[i].expWdata);
         end
         cyc();
      end

      // Read-after-write hazard on rs2 holds the request in STALL until rd 7 retires.
      clearInputs();
      issue(5'd7);
      idReq = 1'b1; idRsAddr[1] = 5'd7; idRsUsed = 3'b010; idRdAddr = 5'd8;
      settle();
      checkOutput("raw_enter_valid", xValid, 0);
      cyc();
      for (int k = 0; k < 3; k++) begin
         settle();
         checkOutput("raw_stall_valid", xValid, 0);
         cyc();
      end
      respond(5'd7, 32'h77, 1'b0);
      settle();
      checkOutput("raw_clear_valid", xValid, 0);
      checkOutput("raw_wb_we", wbWe, 1);
      checkOutput("raw_wb_waddr", wbWaddr, 7);
      checkOutput("raw_wb_wdata", wbWdata, 32'h77);
      cyc();
      xReady = 1'b1; xAccept = 1'b1; xWriteback = 1'b0;
      settle();
      checkOutput("raw_req_valid", xValid, 1);
      checkOutput("raw_req_ready", idReady, 1);
      cyc();
      clearInputs();
      settle();
      checkOutput("raw_busy_done", busy, 0);
      cyc();

      // Scoreboard full at four outstanding: the fifth request waits for a retirement.
      issue(5'd1); issue(5'd2); issue(5'd3); issue(5'd4);
      idReq = 1'b1; idRdAddr = 5'd9;
      settle();
      checkOutput("full_enter_valid", xValid, 0);
      checkOutput("full_busy", busy, 1);
      cyc();
      for (int k = 0; k < 2; k++) begin
         settle();
         checkOutput("full_stall_valid", xValid, 0);
         cyc();
      end
      respond(5'd1, 32'h11, 1'b0);
      settle();
      checkOutput("full_clear_valid", xValid, 0);
      checkOutput("full_wb_waddr1", wbWaddr, 1);
      cyc();
      xReady = 1'b1; xAccept = 1'b1; xWriteback = 1'b1;
      settle();
      checkOutput("full_req_valid", xValid, 1);
      checkOutput("full_req_ready", idReady, 1);
      cyc();
      clearInputs();
      respond(5'd2, 32'h22, 1'b0);
      settle();
      checkOutput("drain2_we", wbWe, 1);
      checkOutput("drain2_wdata", wbWdata, 32'h22);
      respond(5'd3, 32'h33, 1'b0);
      settle();
      checkOutput("drain3_waddr", wbWaddr, 3);
      respond(5'd4, 32'h44, 1'b0);
      settle();
      checkOutput("drain4_waddr", wbWaddr, 4);
      respond(5'd9, 32'h99, 1'b0);
      settle();
      checkOutput("drain9_waddr", wbWaddr, 9);
      checkOutput("drain9_wdata", wbWdata, 32'h99);
      checkOutput("drain_busy", busy, 0);
      cyc();

      // Back-pressure: request fields stay put three cycles, then the coprocessor rejects.
      idReq = 1'b1; idRdAddr = 5'd10; idRsUsed = 3'b111;
      idRs[0] = 32'hA0A0A0A0; idRs[1] = 32'hB1B1B1B1; idRs[2] = 32'hC2C2C2C2;
      settle();
      checkOutput("bp_idle_valid", xValid, 0);
      cyc();
      for (int k = 0; k < 3; k++) begin
         settle();
         checkOutput("bp_valid", xValid, 1);
         checkOutput("bp_ready", idReady, 0);
         checkOutput("bp_illegal", idIllegal, 0);
         checkOutput("bp_rs0", xRs[0], 32'hA0A0A0A0);
         checkOutput("bp_rs1", xRs[1], 32'hB1B1B1B1);
         checkOutput("bp_rs2", xRs[2], 32'hC2C2C2C2);
         checkOutput("bp_rs_valid", {29'd0, xRsValid}, 32'd7);
         checkOutput("bp_rd_clean", xRdClean, 1);
         cyc();
      end
      xReady = 1'b1; xAccept = 1'b0;
      settle();
      checkOutput("rej_ready", idReady, 1);
      checkOutput("rej_illegal", idIllegal, 1);
      cyc();
      clearInputs();
      settle();
      checkOutput("rej_illegal_pulse", idIllegal, 0);
      checkOutput("rej_busy", busy, 0);
      cyc();

      // Error response releases rd 3 without a write; an unissued rd 12 is spurious.
      issue(5'd3);
      respond(5'd3, 32'h33, 1'b1);
      settle();
      checkOutput("err_pulse", xErr, 1);
      checkOutput("err_no_we", wbWe, 0);
      checkOutput("err_busy", busy, 0);
      cyc();
      idReq = 1'b1; idRdAddr = 5'd20; idRsAddr[0] = 5'd3; idRsUsed = 3'b001;
      settle();
      checkOutput("err_pulse_end", xErr, 0);
      cyc();
      xReady = 1'b1; xAccept = 1'b1; xWriteback = 1'b0;
      settle();
      checkOutput("err_rd3_released", xValid, 1);
      cyc();
      clearInputs();
      respond(5'd12, 32'h12, 1'b0);
      settle();
      checkOutput("spur_pulse", spurious, 1);
      checkOutput("spur_no_we", wbWe, 0);
      checkOutput("spur_busy", busy, 0);
      cyc();
      settle();
      checkOutput("spur_pulse_end", spurious, 0);
      cyc();

      // Same-cycle issue of rd 13 and retirement of rd 14 leaves the count at one.
      issue(5'd14);
      idReq = 1'b1; idRdAddr = 5'd13;
      settle();
      cyc();
      xReady = 1'b1; xAccept = 1'b1; xWriteback = 1'b1;
      xRvalid = 1'b1; wbGnt = 1'b1; xRd = 5'd14; xData = 32'hE14;
      settle();
      checkOutput("both_ready", idReady, 1);
      cyc();
      clearInputs();
      settle();
      checkOutput("both_we", wbWe, 1);
      checkOutput("both_waddr", wbWaddr, 14);
      checkOutput("both_busy", busy, 1);
      respond(5'd13, 32'hD13, 1'b0);
      settle();
      checkOutput("both_we13", wbWe, 1);
      checkOutput("both_waddr13", wbWaddr, 13);
      checkOutput("both_busy_done", busy, 0);
      cyc();

      // Reset while requesting with two offloads in flight drops all tracking.
      issue(5'd2); issue(5'd4);
      idReq = 1'b1; idRdAddr = 5'd11;
      settle();
      cyc();
      settle();
      checkOutput("rst_pre_valid", xValid, 1);
      checkOutput("rst_pre_busy", busy, 1);
      rstN = 1'b0;
      cyc();
      rstN = 1'b1; idReq = 1'b0;
      settle();
      checkOutput("rst_x_valid", xValid, 0);
      checkOutput("rst_id_ready", idReady, 0);
      checkOutput("rst_illegal", idIllegal, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_we", wbWe, 0);
      checkOutput("rst_waddr", wbWaddr, 0);
      checkOutput("rst_wdata", wbWdata, 0);
      checkOutput("rst_x_err", xErr, 0);
      checkOutput("rst_spurious", spurious, 0);
      idReq = 1'b1; idRdAddr = 5'd4; idRsAddr[1] = 5'd2; idRsUsed = 3'b010;
      cyc();
      xReady = 1'b1; xAccept = 1'b0;
      settle();
      checkOutput("rst_pending_dropped", xValid, 1);
      checkOutput("rst_post_illegal", idIllegal, 1);
      cyc();
      clearInputs();
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cv32e40p_x_offload_ctrl.md
CV32E40P_X_OFFLOAD_CTRL -- requirements
Module: cv32e40p_x_offload_ctrl

Interface
REQ-001 Parameter: MAX_OUTSTANDING, default 4, max accepted writeback offloads in flight (range 1..15).
REQ-002 clk_i  in  1  single core clock; all state updates on rising edge.
REQ-003 rst_ni  in  1  reset, synchronous and active-low.
REQ-004 id_req_i  in  1  ID stage requests offload of current instruction.
REQ-005 id_rs_i  in  3x32  operand values rs1..rs3 from ID forwarding.
REQ-006 id_rs_addr_i  in  3x5  source register addresses; id_rs_used_i in 3, per-operand used flags.
REQ-007 id_rd_addr_i  in  5  destination register address.
REQ-008 id_ready_o  out  1  offload handshake finished this cycle (accepted or rejected).
REQ-009 id_illegal_o  out  1  one-cycle pulse: coprocessor rejected instruction.
REQ-010 x_valid_o out 1; x_ready_i in 1; x_rs_o out 3x32; x_rs_valid_o out 3; x_rd_clean_o out 1; x_accept_i in 1; x_writeback_i in 1  X request channel.
REQ-011 x_rvalid_i in 1; x_rready_o out 1; x_rd_i in 5; x_data_i in 32; x_error_i in 1  X response channel.
REQ-012 wb_gnt_i in 1 (regfile port free); wb_we_o out 1; wb_waddr_o out 5; wb_wdata_o out 32  regfile write port.
REQ-013 x_err_o out 1 (response error pulse); spurious_o out 1 (response for non-pending rd); busy_o out 1 (outstanding count nonzero or FSM not IDLE).

Function
REQ-014 FSM states IDLE, STALL, REQ; encoded in registered state, one transition per cycle max.
REQ-015 Hazard = any used rs address with pending bit set, OR id_rd_addr_i pending, OR outstanding count == MAX_OUTSTANDING.
REQ-016 IDLE: id_req_i & hazard -> STALL; id_req_i & no hazard -> REQ; else stay.
REQ-017 STALL: x_valid_o low; move to REQ in cycle after hazard clears; id_req_i drop -> IDLE.
REQ-018 REQ: x_valid_o high, x_rs_o = id_rs_i, x_rs_valid_o = id_rs_used_i, x_rd_clean_o = 1; x_valid_o held until x_valid_o & x_ready_i; request fields stable while waiting.
REQ-019 Handshake cycle: id_ready_o = 1, return to IDLE next cycle; no back-to-back handshake (min 2 cycles between handshakes).
REQ-020 Handshake with x_accept_i & x_writeback_i & rd != 0: set pending[rd], count +1 next cycle.
REQ-021 Handshake with x_accept_i & x_writeback_i & rd == 0: count +1, no pending bit.
REQ-022 Handshake with x_accept_i & !x_writeback_i: no state change beyond FSM.
REQ-023 Handshake with !x_accept_i: id_illegal_o = 1 same cycle; no scoreboard change.
REQ-024 x_rready_o = wb_gnt_i combinationally; response consumed on x_rvalid_i & x_rready_o.
REQ-025 Consumed response: count -1, pending[x_rd_i] cleared next cycle.
REQ-026 Consumed response, !x_error_i, x_rd_i != 0, pending[x_rd_i] set: wb_we_o = 1 next cycle, wb_waddr_o = x_rd_i, wb_wdata_o = x_data_i (1-cycle registered latency); wb_we_o low otherwise.
REQ-027 x_error_i on consumed response: x_err_o pulse next cycle, no write, pending/count still released.
REQ-028 Consumed response with pending[x_rd_i] clear and x_rd_i != 0: spurious_o pulse next cycle, no write, count still decremented if nonzero.
REQ-029 Count never wraps: decrement at 0 suppressed; issue at MAX_OUTSTANDING impossible by REQ-015.
REQ-030 Same-cycle issue and response: count unchanged; pending set and clear on different rd both applied.
REQ-031 pending bit 0 constantly 0.

Reset
REQ-032 rst_ni low at clock edge: FSM IDLE, pending all 0, count 0, x_valid_o 0, id_ready_o 0, id_illegal_o 0, wb_we_o 0, wb_waddr_o 0, wb_wdata_o 0, x_err_o 0, spurious_o 0, busy_o 0.
REQ-033 Reset mid-REQ or with outstanding responses: all in-flight tracking dropped; x_valid_o low cycle after reset edge.

Verification
REQ-034 Offload rd=5, x_ready_i=1, accept=1, writeback=1 -> id_ready_o 1 on handshake, busy_o 1; response rd=5 data 0xDEADBEEF, wb_gnt_i=1 -> next cycle wb_we_o 1, waddr 5, wdata 0xDEADBEEF, busy_o 0 after.
REQ-035 Pending rd=7, new request rs2=7 used -> STALL, x_valid_o 0 until response rd=7 consumed, then REQ next cycle.
REQ-036 MAX_OUTSTANDING=4 writeback offloads rd=1..4 accepted, fifth request rd=9 -> STALL until one response consumed.
REQ-037 Request with x_ready_i low 3 cycles -> x_valid_o and x_rs_o stable 3 cycles; then accept=0 -> id_illegal_o 1 for one cycle, count 0.
REQ-038 Response rd=3 x_error_i=1 -> x_err_o pulse, wb_we_o 0, pending[3] 0; response rd=12 never issued -> spurious_o pulse.
REQ-039 rst_ni low during REQ with count=2 -> all outputs per REQ-032 next cycle.
